// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one result bit per clock, LSB first.
// Diff/Borrow are loaded once per operation and held until the next completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;

    logic             d_s;
    logic             br_next_s;
    logic [WIDTH-1:0] res_next_s;

    function automatic logic diff_bit(input logic a0, input logic b0, input logic br);
        return a0 ^ b0 ^ br;
    endfunction

    function automatic logic borrow_bit(input logic a0, input logic b0, input logic br);
        return (~a0 & b0) | (~(a0 ^ b0) & br);
    endfunction

    // Full-adder-style borrow cell on the current operand LSBs
    always_comb begin
        d_s        = diff_bit(a_r[0], b_r[0], br_r);
        br_next_s  = borrow_bit(a_r[0], b_r[0], br_r);
        res_next_s = WIDTH'({d_s, res_r} >> 1);
    end

    // Control FSM with datapath and registered status/result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            br_r    <= 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Diff    <= '0;
            Borrow  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= in1;
                        b_r     <= in2;
                        br_r    <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    res_r <= res_next_s;
                    a_r   <= a_r >> 1;
                    b_r   <= b_r >> 1;
                    br_r  <= br_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    // Last bit: publish the result in the same edge that enters DONE
                    if (cnt_r == CNT_LAST) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        Diff    <= res_next_s;
                        Borrow  <= br_next_s;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for latency, hold,
// back-to-back and reset-abort cases, and a 2-bit instance swept exhaustively.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         tests_run = 0;
    int         tests_failed = 0;

    logic       start8;
    logic [7:0] a8, b8, diff8;
    logic       busy8, done8, borrow8;

    logic       start2;
    logic [1:0] a2, b2, diff2;
    logic       busy2, done2, borrow2;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .in1(a8), .in2(b8),
        .busy(busy8), .done(done8), .Diff(diff8), .Borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in1(a2), .in2(b2),
        .busy(busy2), .done(done2), .Diff(diff2), .Borrow(borrow2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for done8, returns cycles waited
    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at a negedge in IDLE; runs one op and checks latency, hold and result
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_d, input logic exp_b, input string tag);
        logic [7:0] prev_d;
        logic       prev_b;
        int         n;
        int         unstable;
        prev_d = diff8;
        prev_b = borrow8;
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~a;
        b8 = b ^ 8'h5A;
        check({tag, "_busy"}, 32'(busy8), 32'd1);
        n = 1;
        unstable = 0;
        while (!done8 && n < 20) begin
            if (diff8 !== prev_d || borrow8 !== prev_b) unstable++;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd9);
        check({tag, "_hold_in_shift"}, 32'(unstable), 32'd0);
        check({tag, "_diff"}, 32'(diff8), 32'(exp_d));
        check({tag, "_borrow"}, 32'(borrow8), 32'(exp_b));
        check({tag, "_busy_in_done"}, 32'(busy8), 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done8), 32'd0);
        check({tag, "_diff_held_idle"}, 32'(diff8), 32'(exp_d));
    endtask

    initial begin
        int         n;
        int         t0, t1, t2;
        int         ndone;
        logic [1:0] ed;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start2 = 1'b0; a2 = 2'd0;  b2 = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_borrow", 32'(borrow8), 32'd0);
        check("rst_diff_w2", 32'(diff2), 32'd0);

        // First edge after reset release accepts start
        rst_n = 1'b1;
        run_op8(8'h35, 8'h12, 8'h23, 1'b0, "op_35_12");
        run_op8(8'h00, 8'h01, 8'hFF, 1'b1, "op_00_01");
        run_op8(8'hA5, 8'hA5, 8'h00, 1'b0, "op_a5_a5");
        run_op8(8'h12, 8'h35, 8'hDD, 1'b1, "op_12_35");
        run_op8(8'hFF, 8'h00, 8'hFF, 1'b0, "op_ff_00");

        // start held high: back-to-back accepts, operands changed while busy
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h03;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy8 && n < 5);
        t0 = cyc;
        a8 = 8'h40; b8 = 8'h05;
        wait_done8(n);
        check("cont1_diff", 32'(diff8), 32'h0D);
        check("cont1_borrow", 32'(borrow8), 32'd0);
        @(negedge clk);
        check("cont1_gap_busy", 32'(busy8), 32'd0);
        @(negedge clk);
        check("cont2_busy", 32'(busy8), 32'd1);
        t1 = cyc;
        check("cont2_spacing", 32'(t1 - t0), 32'd10);
        a8 = 8'h02; b8 = 8'h09;
        wait_done8(n);
        check("cont2_diff", 32'(diff8), 32'h3B);
        check("cont2_borrow", 32'(borrow8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("cont3_busy", 32'(busy8), 32'd1);
        t2 = cyc;
        check("cont3_spacing", 32'(t2 - t1), 32'd10);
        start8 = 1'b0;
        wait_done8(n);
        check("cont3_diff", 32'(diff8), 32'hF9);
        check("cont3_borrow", 32'(borrow8), 32'd1);
        @(negedge clk);

        // Reset during the 4th SHIFT cycle aborts without a done pulse
        start8 = 1'b1; a8 = 8'h35; b8 = 8'h12;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_diff", 32'(diff8), 32'd0);
        check("abort_borrow", 32'(borrow8), 32'd0);
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run_op8(8'h80, 8'h7F, 8'h01, 1'b0, "op_80_7f");

        // WIDTH=2 exhaustive sweep against (a-b) mod 4 and a<b
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                start2 = 1'b1;
                a2 = 2'(i);
                b2 = 2'(j);
                @(negedge clk);
                start2 = 1'b0;
                n = 0;
                while (!done2 && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                ed = 2'(i - j);
                check($sformatf("w2_diff_%0d_%0d", i, j), 32'(diff2), 32'(ed));
                check($sformatf("w2_borrow_%0d_%0d", i, j), 32'(borrow2), 32'(i < j));
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset that is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port in1, input, WIDTH bits: minuend, unsigned.
REQ-006 The block SHALL have port in2, input, WIDTH bits: subtrahend, unsigned.
REQ-007 The block SHALL have port busy, output, 1 bit: high while the serial computation runs.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that Diff and Borrow are valid.
REQ-009 The block SHALL have port Diff, output, WIDTH bits: registered result, in1 - in2 modulo 2^WIDTH.
REQ-010 The block SHALL have port Borrow, output, 1 bit: registered borrow-out, high iff in1 < in2 (unsigned).

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT and DONE.
REQ-012 In IDLE, when start=1 is sampled, the block SHALL capture in1 and in2 into operand shift registers, clear the internal borrow flop, clear the bit counter and enter SHIFT.
REQ-013 In IDLE, when start=0 is sampled, the block SHALL remain in IDLE with all registers unchanged.
REQ-014 On each SHIFT cycle, the block SHALL compute d = a0 XOR b0 XOR br from the operand LSBs a0, b0 and the borrow flop br.
REQ-015 On each SHIFT cycle, the block SHALL compute br_next = (NOT a0 AND b0) OR (NOT(a0 XOR b0) AND br).
REQ-016 On each SHIFT cycle, the block SHALL shift d into the result register from the MSB end, shift both operand registers right by one bit, and increment the counter.
REQ-017 After exactly WIDTH SHIFT cycles, the block SHALL enter DONE, loading Diff from the result register and Borrow from the final br_next.
REQ-018 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-019 busy SHALL be 1 exactly when the state is SHIFT; done SHALL be 1 exactly when the state is DONE.
REQ-020 Latency: if start is sampled at edge k, busy SHALL be high for cycles k+1..k+WIDTH and done SHALL be high only in cycle k+WIDTH+1.
REQ-021 start SHALL be ignored in SHIFT and in DONE; there is no queueing, so the next accept is possible only from IDLE, one cycle after done.
REQ-022 Changes on in1 and in2 after the accept edge SHALL have no effect on the operation in progress.
REQ-023 Diff and Borrow SHALL hold their values from the last DONE until the next DONE, including through IDLE and SHIFT.
REQ-024 Operand registers, result register and borrow flop SHALL each be exactly WIDTH bits or 1 bit; no extension and no saturation.
REQ-025 The bit counter SHALL be clog2(WIDTH+1) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-026 When rst_n=0 is sampled at an edge, the block SHALL enter IDLE and clear busy, done, Diff, Borrow, the counter, the operand registers and the borrow flop to 0.
REQ-027 Reset SHALL take priority over start and SHALL abort any operation in SHIFT or DONE; no done pulse SHALL follow for an aborted operation.
REQ-028 The first edge with rst_n=1 SHALL be able to accept start.

Verification
REQ-029 WIDTH=8, start with in1=0x35, in2=0x12 -> done pulses 9 cycles after accept, Diff=0x23, Borrow=0.
REQ-030 WIDTH=8, in1=0x00, in2=0x01 -> Diff=0xFF, Borrow=1; and in1=0xA5, in2=0xA5 -> Diff=0x00, Borrow=0.
REQ-031 WIDTH=8, start held high continuously -> accepts spaced exactly WIDTH+2 cycles apart, a new accept one cycle after each done, and operand changes during busy have no effect.
REQ-032 WIDTH=8, rst_n driven low for 1 cycle at the 4th SHIFT cycle -> next cycle busy=0, done=0, Diff=0x00, Borrow=0, with no done pulse afterwards until a new start.
REQ-033 WIDTH=2, all 16 operand pairs applied -> every Diff and Borrow matches the (in1 - in2) mod 4 and in1<in2 reference model.
REQ-034 Between operations -> Diff and Borrow stay stable through IDLE and through the SHIFT cycles of the next operation.
